// File: rtl/image_scan_fetcher_pkg.sv
// Shared constants and types for the image RAM read-side fetcher.
package image_scan_pkg;

    localparam int IMG_W        = 500;
    localparam int IMG_H        = 250;
    localparam int PIX_PER_WORD = 4;
    localparam int NUM_WORDS    = 31250;
    localparam int ADDR_W       = 15;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  pixel_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/image_scan_fetcher_fifo.sv
// Prefetch word FIFO for image_scan_fetcher. It is show-ahead: dout is always the oldest word.
// A synchronous flush empties it, and reset has the same effect.
module scan_word_fifo
    import image_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  word_t                  din,
    output word_t                  dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/image_scan_fetcher.sv
// Streams one frame of RGB332 pixels from image RAM port 2 into a valid/ready pixel stream.
// Optional: define IMAGE_SCAN_FETCHER_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module image_scan_fetcher #(
    parameter int NUM_WORDS  = image_scan_pkg::NUM_WORDS,
    parameter int ADDR_W     = image_scan_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sof,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
`ifdef IMAGE_SCAN_FETCHER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);
    import image_scan_pkg::*;

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                WA_W      = ADDR_W + 1;
    localparam logic [WA_W-1:0]   END_WORD  = WA_W'(NUM_WORDS);
    localparam logic [WA_W-1:0]   LAST_WORD = WA_W'(NUM_WORDS - 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    state_t            state;
    logic [WA_W-1:0]   word_addr;
    logic [WA_W-1:0]   pop_word;
    logic [ADDR_W-1:0] last_addr;
    logic [1:0]        byte_idx;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    word_t             fifo_dout;
    pixel_t            cur_pixel;
    logic              issue;
    logic              handshake;
    logic              pop;

    // The head of the FIFO is the word being unpacked, so its occupancy plus the
    // read in flight bounds every word that has been requested but not yet drained.
    // Reads are never issued on a sof cycle, so nothing stale returns after a restart.
    assign issue = !reset && !sof && (state == FETCH) && (word_addr < END_WORD) &&
                   (({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C);

    assign pix_valid  = (fifo_count != '0);
    assign cur_pixel  = fifo_dout[{byte_idx, 3'b000} +: 8];
    assign pix_data   = pix_valid ? cur_pixel : 8'h00;
    assign handshake  = pix_valid && pix_ready;
    assign pop        = handshake && (byte_idx == 2'd3);
    assign frame_done = pop && (pop_word == LAST_WORD) && (state == FETCH);
    assign busy       = (state == FETCH);
    assign underrun   = busy && pix_ready && !pix_valid;

    assign ram_chipselect = issue;
    assign ram_address    = issue ? word_addr[ADDR_W-1:0] : last_addr;
    assign ram_clken      = !reset;

    scan_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (sof),
        .push  (inflight),
        .pop   (pop),
        .din   (ram_readdata),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // sof takes priority over the final handshake so a back-to-back frame restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_addr <= '0;
            pop_word  <= '0;
            last_addr <= '0;
            byte_idx  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                last_addr <= word_addr[ADDR_W-1:0];
                word_addr <= word_addr + WA_W'(1);
            end
            if (sof) begin
                state     <= FETCH;
                word_addr <= '0;
                pop_word  <= '0;
                byte_idx  <= '0;
            end else begin
                if (handshake)  byte_idx <= byte_idx + 2'd1;
                if (pop)        pop_word <= pop_word + WA_W'(1);
                if (frame_done) state    <= IDLE;
            end
        end
    end

`ifdef IMAGE_SCAN_FETCHER_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || (sof && state == IDLE)) begin
            underrun_count <= '0;
        end else if (underrun && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/image_scan_fetcher.md
Name: image_scan_fetcher

Overview:
- Read-side sequencer for the image RAM's second port (s2): streams one full frame of 8-bit RGB332 pixels to the VGA output pipeline.
- Issues word reads through the RAM port, which has a registered address and unregistered output, so read latency is 1 cycle.
- Buffers fetched words in a small prefetch FIFO and unpacks each 32-bit word into 4 pixels on a valid/ready stream.
- Image is 500x250 pixels = 125000 pixels = 31250 words, matching the RAM depth.

Parameters:
- NUM_WORDS, 31250: words per frame; last address is NUM_WORDS-1.
- ADDR_W, 15: RAM word-address width.
- FIFO_DEPTH, 4: prefetch FIFO depth in 32-bit words; power of two, >=2.

Ports:
- clk  in  1  single clock, shared with RAM clk2.
- reset  in  1  synchronous, active-high; fixed as synchronous and active-high.
- sof  in  1  start-of-frame pulse; (re)starts fetch at word 0.
- ram_address  out  15  RAM port-2 word address.
- ram_chipselect  out  1  read strobe; one word is requested per asserted cycle.
- ram_clken  out  1  tied 1 whenever reset=0.
- ram_readdata  in  32  RAM data, valid exactly 1 cycle after ram_chipselect.
- pix_data  out  8  current pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  consumer accepts pixel.
- busy  out  1  high from sof until the last pixel is accepted.
- frame_done  out  1  1-cycle pulse when the last pixel is accepted.
- underrun  out  1  1-cycle pulse: pix_ready=1, pix_valid=0 while busy.

Behaviour:
- Reset: every output is 0, including ram_clken. State IDLE, FIFO empty, word_addr=0, byte_idx=0, inflight=0.
- IDLE: no reads issued. On sof: go to FETCH; busy=1 from the next cycle.
- FETCH read issue: a read is issued in any cycle where word_addr<NUM_WORDS and fifo_count+inflight<FIFO_DEPTH.
  - Issue means ram_chipselect=1, ram_address=word_addr, then word_addr++.
  - inflight is 1 for the cycle after an issue.
  - Back-to-back issues are allowed, giving 1 word/cycle sustained throughput.
  - ram_readdata is pushed into the FIFO on the cycle after the issue.
- ram_chipselect=0 in every cycle with no issue. ram_address holds its last value.
- Unpacker:
  - Holds the current word. pix_data=word[8*byte_idx+7 : 8*byte_idx]; byte 0 (bits 7:0) is output first.
  - Handshake at pix_valid & pix_ready: byte_idx++. At byte_idx==3, the next word is popped from the FIFO if present, otherwise pix_valid drops.
  - pix_data and pix_valid hold stable while pix_valid & !pix_ready.
  - First-pixel latency after sof: 3 cycles. Cycle 1 issues the read, cycle 2 pushes, cycle 3 loads the unpacker and asserts pix_valid.
- End of frame:
  - The handshake on byte 3 of word NUM_WORDS-1 produces the frame_done pulse.
  - In the next cycle: busy=0, pix_valid=0, state IDLE.
- sof while busy:
  - Restarts the frame: FIFO flushed, unpacker emptied, word_addr=0.
  - Any read returning in the next cycle is discarded.
  - pix_valid=0 in the cycle after sof. No frame_done is produced for the aborted frame.
- sof on the same cycle as the final handshake: sof wins. frame_done still pulses, and FETCH restarts.
- reset mid-frame: same as power-on reset; the returning read data is ignored.
- underrun: informational only, no state change; never asserted in IDLE.
- Address wrap: word_addr never exceeds NUM_WORDS. No read is issued beyond NUM_WORDS-1.

Optional Feature:
- Macro: IMAGE_SCAN_FETCHER_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_count[15:0], a saturating count of underrun pulses (saturates at 0xFFFF).
  - Cleared by reset, and by sof only while IDLE.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package image_scan_pkg holds:
  - Constants IMG_W=500, IMG_H=250, PIX_PER_WORD=4, NUM_WORDS=31250, ADDR_W=15.
  - Typedef word_t (32 bits), pixel_t (8 bits), state_t {IDLE, FETCH}.
- Sub-module scan_word_fifo: synchronous FIFO, FIFO_DEPTH x 32.
  - Ports: push, pop, din, dout, count.
  - Synchronous flush input; reset behaves like flush.

Test Plan:
- Reset then sof with pix_ready=1 and a RAM model holding word k = {k[7:0]+3, k[7:0]+2, k[7:0]+1, k[7:0]}:
  - pix_valid rises 3 cycles after sof.
  - Pixels run 0x00,0x01,0x02,0x03,0x01,0x02,... continuously.
  - frame_done occurs exactly at pixel 124999; ram_address sequence is 0..31249 with no repeats.
- Backpressure with pix_ready toggling 1-of-5 cycles:
  - pix_data is stable while stalled.
  - fifo_count+inflight never exceeds 4.
  - No reads are issued while the FIFO is full.
  - Full frame matches the reference order.
- Mid-frame restart: sof at pixel 1000 (word 250 in flight):
  - pix_valid=0 the next cycle.
  - Next pixel is word 0 byte 0.
  - The stale word 250 never appears; no frame_done for the aborted frame.
- Underrun: NUM_WORDS overridden to 8, and pix_ready held high before the first pixel arrives:
  - underrun pulses on the 2 cycles preceding the first pixel, then never again (1 word/cycle sustains 4 pixels/word).
  - With the macro defined, underrun_count=2.
- sof coinciding with the final handshake (NUM_WORDS=8):
  - frame_done pulses, busy stays 1, and the next frame restarts at address 0.
- Reset asserted mid-frame for 1 cycle:
  - All outputs are 0 on the next cycle.
  - No reads occur until sof; the following frame is correct from word 0.
